// File: rtl/rfblackwidow_cmp_seq_if.sv
// rtl/rfblackwidow_cmp_seq_if.sv - request/response bundle for the chunk-serial compare engine
interface rfblackwidow_cmp_seq_if #(
   parameter int LANES = 4,
   parameter int WID   = 64,
   parameter int TAGW  = 4
);
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic [2:0]            op_i;
   logic                  signed_i;
   logic                  use_imm_i;
   logic [LANES*WID-1:0]  a_i;
   logic [LANES*WID-1:0]  b_i;
   logic [WID-1:0]        imm_i;
   logic [LANES-1:0]      lane_en_i;
   logic [TAGW-1:0]       tag_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [LANES-1:0]      res_o;
   logic [TAGW-1:0]       tag_o;

   modport master (
      output in_valid_i, op_i, signed_i, use_imm_i, a_i, b_i, imm_i, lane_en_i, tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, res_o, tag_o
   );

   modport slave (
      input  in_valid_i, op_i, signed_i, use_imm_i, a_i, b_i, imm_i, lane_en_i, tag_i, out_ready_i,
      output in_ready_o, out_valid_o, res_o, tag_o
   );
endinterface

// File: rtl/rfblackwidow_cmp_seq.sv
// rtl/rfblackwidow_cmp_seq.sv - multi-lane MSB-chunk-first compare engine with early-out
module rfblackwidow_cmp_seq #(
   parameter int LANES = 4,
   parameter int WID   = 64,
   parameter int CHUNK = 16,
   parameter int TAGW  = 4
) (
   input logic                   clk_i,
   input logic                   rst_ni,
   rfblackwidow_cmp_seq_if.slave bus
);
   localparam int NCHUNK = WID / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

   generate
      if (WID % CHUNK != 0) begin : g_bad_chunk
         $error("WID must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic                 in_ready_q, out_valid_q;
   logic [LANES-1:0]     res_q;
   logic [TAGW-1:0]      tag_out_q, tag_q;
   logic [LANES*WID-1:0] a_q, b_q;
   logic [2:0]           op_q;
   logic                 sgn_q;
   logic [LANES-1:0]     en_q, dec_q, lt_q;
   logic [IW-1:0]        idx_q;

   logic [LANES-1:0]     dec_n, lt_n, res_n;
   logic [CHUNK-1:0]     a_c, b_c;
   logic                 eq, last;

   // Lanes already decided keep their verdict; only the first unequal chunk counts.
   always_comb begin
      dec_n = dec_q;
      lt_n  = lt_q;
      res_n = '0;
      a_c   = '0;
      b_c   = '0;
      eq    = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         a_c = a_q[l*WID + int'(idx_q)*CHUNK +: CHUNK];
         b_c = b_q[l*WID + int'(idx_q)*CHUNK +: CHUNK];
         if (sgn_q && idx_q == TOP) begin
            a_c[CHUNK-1] = ~a_c[CHUNK-1];
            b_c[CHUNK-1] = ~b_c[CHUNK-1];
         end
         if (en_q[l] && !dec_q[l] && a_c != b_c) begin
            dec_n[l] = 1'b1;
            lt_n[l]  = a_c < b_c;
         end
         eq = !dec_n[l];
         case (op_q)
            3'd0:    res_n[l] = en_q[l] & eq;
            3'd1:    res_n[l] = en_q[l] & !eq;
            3'd2:    res_n[l] = en_q[l] & lt_n[l];
            3'd3:    res_n[l] = en_q[l] & !lt_n[l];
            3'd4:    res_n[l] = en_q[l] & (lt_n[l] | eq);
            3'd5:    res_n[l] = en_q[l] & !lt_n[l] & !eq;
            default: res_n[l] = 1'b0;
         endcase
      end
      last = (idx_q == '0) || (&(dec_n | ~en_q));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         tag_out_q   <= '0;
         tag_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         sgn_q       <= 1'b0;
         en_q        <= '0;
         dec_q       <= '0;
         lt_q        <= '0;
         idx_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid_i && in_ready_q) begin
                  a_q        <= bus.a_i;
                  b_q        <= bus.use_imm_i ? {LANES{bus.imm_i}} : bus.b_i;
                  op_q       <= bus.op_i;
                  sgn_q      <= bus.signed_i;
                  en_q       <= bus.lane_en_i;
                  tag_q      <= bus.tag_i;
                  dec_q      <= '0;
                  lt_q       <= '0;
                  idx_q      <= TOP;
                  in_ready_q <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               dec_q <= dec_n;
               lt_q  <= lt_n;
               if (last) begin
                  res_q       <= res_n;
                  tag_out_q   <= tag_q;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready_o  = in_ready_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.res_o       = res_q;
   assign bus.tag_o       = tag_out_q;
endmodule

// File: doc/rfblackwidow_cmp_seq.md
Name: rfblackwidow_cmp_seq

Overview:
Multi-lane, chunk-serial compare engine for the BlackWidow SIMD/wide-integer path. Each accepted operation compares LANES operand pairs of WID bits. Operands are processed CHUNK bits per cycle, most-significant chunk first, with early termination once every enabled lane is decided. It produces a per-lane predicate mask under a valid/ready handshake and sits between register read and predicate writeback.

Parameters:
LANES, 4, number of independent compare lanes
WID, 64, operand width per lane; WID % CHUNK must be 0 (elaboration error otherwise)
CHUNK, 16, bits compared per cycle; NCHUNK = WID/CHUNK
TAGW, 4, width of pass-through operation tag

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  operation request
in_ready_o  out  1  engine can accept (IDLE)
op_i  in  3  0 EQ, 1 NE, 2 LT, 3 GE, 4 LE, 5 GT, 6/7 reserved
signed_i  in  1  1 = two's-complement compare, 0 = unsigned
use_imm_i  in  1  1 = imm_i replaces every lane's b operand
a_i  in  LANES*WID  lane operands A, lane 0 in LSBs
b_i  in  LANES*WID  lane operands B
imm_i  in  WID  immediate, already extended to WID by decode
lane_en_i  in  LANES  per-lane enable
tag_i  in  TAGW  operation tag
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
res_o  out  LANES  predicate per lane
tag_o  out  TAGW  tag of the result

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready_o=1, out_valid_o=0, res_o=0, tag_o=0, all lane state cleared.
- Clock is clk_i; reset is asynchronous and active-low on rst_ni.
- FSM states:
  - IDLE: accept when in_valid_i&in_ready_o. Latch a, b-or-imm, op, signed, lane_en, tag. Clear per-lane decided/lt flags. Chunk index = NCHUNK-1. Next state RUN.
  - RUN: each cycle compares chunk[idx] of every undecided enabled lane.
    - Signed mode inverts the MSB of the top chunk only.
    - Unequal chunk: set decided=1, lt=(a_chunk<b_chunk).
    - Go to DONE when idx==0 or all enabled lanes are decided (early-out); otherwise idx-1.
  - DONE: out_valid_o=1, and res_o/tag_o stay stable. On out_valid_o&out_ready_i go to IDLE.
- in_ready_o=1 only in IDLE; no overlap of operations.
- Latency: out_valid_o asserts k edges after the accept edge, k = chunks processed (1..NCHUNK). When lane_en_i=0 in every lane, k=1.
- Result per enabled lane: eq=!decided; EQ=eq, NE=!eq, LT=lt, GE=!lt, LE=lt|eq, GT=!lt&!eq.
- Disabled lanes and reserved ops yield 0. Reserved ops still take the normal path and timing.
- res_o is registered; it updates on entry to DONE and holds until the next DONE.
- Inputs are ignored outside the IDLE accept cycle; changes to a_i/b_i during RUN have no effect.
- Backpressure: DONE holds indefinitely while out_ready_i=0.
- Reset mid-operation aborts immediately. No result is emitted, and the engine is in IDLE on release.

Test Plan:
- LANES=4, WID=64, CHUNK=16, lane0 a=0xFFFF_FFFF_FFFF_FFFF, b=1, LT: signed_i=1 -> res_o[0]=1, out_valid 1 edge after accept (top-chunk decide). signed_i=0 -> res_o[0]=0, same latency.
- All lanes a=b=0x1234_5678_9ABC_DEF0, op EQ -> res_o=4'b1111 after 4 edges. Op NE -> 4'b0000. Op LE -> 4'b1111.
- Lane0 differs only in bit 0 (a=2, b=3), other lanes differ in the top chunk. Op LT -> 4 edges (no early-out), res_o[0]=1.
- use_imm_i=1, imm_i=5, a lanes = {4,5,6,-3}, signed GT -> res_o=4'b0100. Repeat with lane_en_i=4'b0011 -> res_o=4'b0000.
- Hold out_ready_i=0 for 10 cycles in DONE -> out_valid_o, res_o and tag_o stable, in_ready_o=0. Assert out_ready_i -> IDLE next edge, and a new op is accepted.
- Drop rst_ni during RUN with chunk 2 pending -> out_valid_o=0 and in_ready_o=1 immediately (async). A reserved op 7 then returns res_o=0 with normal handshake.
